// File: rtl/morse_pkg.sv
// Shared types, timing constants and digit-to-pattern lookup for the Morse keyer.
// MORSE_WORD_GAP_EN adds the WGAP state for the 4'hF word-space code.
package morse_pkg;

  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned PATTERN_W       = 5;
  localparam int unsigned SYMBOLS         = 5;
  localparam int unsigned DOT_UNITS       = 1;
  localparam int unsigned DASH_UNITS      = 3;
  localparam int unsigned SYM_GAP_UNITS   = 1;
  localparam int unsigned CHAR_GAP_UNITS  = 3;
  localparam int unsigned WORD_GAP_UNITS  = 7;
  localparam logic [DIGIT_W-1:0] WORD_SPACE_CODE = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    CGAP
`ifdef MORSE_WORD_GAP_EN
    , WGAP
`endif
  } state_t;

  // Bit 0 is the first symbol sent; 1 = dash.
  function automatic logic [PATTERN_W-1:0] digit_pattern(input logic [DIGIT_W-1:0] digit);
    logic [PATTERN_W-1:0] pat;
    case (digit)
      4'd0:    pat = 5'b11111;
      4'd1:    pat = 5'b11110;
      4'd2:    pat = 5'b11100;
      4'd3:    pat = 5'b11000;
      4'd4:    pat = 5'b10000;
      4'd5:    pat = 5'b00000;
      4'd6:    pat = 5'b00001;
      4'd7:    pat = 5'b00011;
      4'd8:    pat = 5'b00111;
      4'd9:    pat = 5'b01111;
      default: pat = 5'b00000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/morse_fifo.sv
// Synchronous FIFO with an extra pointer wrap bit; full/empty are registered flags.
module morse_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic             do_push, do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign wr_ptr_n = wr_ptr + PW'(do_push);
  assign rd_ptr_n = rd_ptr + PW'(do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Flags are computed from the next pointers so they settle with the pointers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      empty  <= (wr_ptr_n == rd_ptr_n);
      full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Queued BCD digit to serial Morse keying line with standard unit timing.
// Optional MORSE_WORD_GAP_EN accepts 4'hF as a 7-unit word space.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               key_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned CNT_W   = $clog2(UNIT_CYCLES * WORD_GAP_UNITS);
  localparam int unsigned SYM_W   = 3;
  localparam int unsigned UNITS_W = 3;

  state_t               state, state_n, load_state;
  logic [CNT_W-1:0]     cnt, cnt_n, end_cnt;
  logic [SYM_W-1:0]     sym_idx, sym_n;
  logic [PATTERN_W-1:0] pattern, pattern_n;
  logic [UNITS_W-1:0]   units;
  logic                 unit_done;
  logic                 key_n, busy_n, err_n;
  logic                 code_ok, take, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [DIGIT_W-1:0]   head;

  // Input acceptance: invalid codes complete the handshake but are dropped.
  always_comb begin
    code_ok = (digit_i <= 4'd9);
`ifdef MORSE_WORD_GAP_EN
    if (digit_i == WORD_SPACE_CODE) begin
      code_ok = 1'b1;
    end
`endif
  end

  assign ready_o = ~fifo_full;
  assign take    = valid_i & ready_o;
  assign push    = take & code_ok;

  morse_fifo #(
    .WIDTH (DIGIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (digit_i),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State to enter when the FIFO head is popped.
  always_comb begin
    load_state = MARK;
`ifdef MORSE_WORD_GAP_EN
    if (head == WORD_SPACE_CODE) begin
      load_state = WGAP;
    end
`endif
  end

  // Length of the current state in units and its terminal count.
  always_comb begin
    units = UNITS_W'(DOT_UNITS);
    case (state)
      MARK:    units = pattern[0] ? UNITS_W'(DASH_UNITS) : UNITS_W'(DOT_UNITS);
      SPACE:   units = UNITS_W'(SYM_GAP_UNITS);
      CGAP:    units = UNITS_W'(CHAR_GAP_UNITS);
`ifdef MORSE_WORD_GAP_EN
      WGAP:    units = UNITS_W'(WORD_GAP_UNITS);
`endif
      default: units = UNITS_W'(DOT_UNITS);
    endcase
    end_cnt = CNT_W'(32'(units) * UNIT_CYCLES - 32'd1);
  end

  assign unit_done = (cnt == end_cnt);

  // Next-state, counters and output decode.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    sym_n     = sym_idx;
    pattern_n = pattern;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_n   = load_state;
          pattern_n = digit_pattern(head);
          sym_n     = '0;
        end
      end
      MARK: begin
        if (unit_done) begin
          cnt_n   = '0;
          state_n = (sym_idx == SYM_W'(SYMBOLS - 1)) ? CGAP : SPACE;
        end
      end
      SPACE: begin
        if (unit_done) begin
          cnt_n     = '0;
          sym_n     = sym_idx + SYM_W'(1);
          pattern_n = pattern >> 1;
          state_n   = MARK;
        end
      end
      default: begin
        // CGAP/WGAP: chain straight into the next queued code with no idle cycle.
        if (unit_done) begin
          cnt_n = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_n   = load_state;
            pattern_n = digit_pattern(head);
            sym_n     = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
    key_n  = (state == MARK);
    busy_n = (state_n != IDLE) | ~fifo_empty;
    err_n  = take & ~code_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sym_idx <= '0;
      pattern <= '0;
      key_o   <= 1'b0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sym_idx <= sym_n;
      pattern <= pattern_n;
      key_o   <= key_n;
      busy_o  <= busy_n;
      err_o   <= err_n;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: per-digit vector table plus queue-based run-length scoreboard.
`timescale 1ns/1ps
module tb_morse_keyer;

  localparam int U     = 4;
  localparam int DEPTH = 4;
  localparam int BOUND = 3000;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] digit   = 4'd0;
  logic       valid   = 1'b0;
  logic       ready, key, busy, err;

  always #5 clk = ~clk;

  morse_keyer #(.UNIT_CYCLES(U), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .digit_i (digit),
    .valid_i (valid),
    .ready_o (ready),
    .key_o   (key),
    .busy_o  (busy),
    .err_o   (err)
  );

  // pat: MSB is the first symbol sent, 1 = dash; units: full character time incl. trailing gap
  typedef struct {
    logic [3:0] code;
    bit         ok;
    bit         space;
    logic [4:0] pat;
    int         units;
  } vec_t;

  vec_t vecs[$];
  int   exp_q[$];   // >0 mark length, <0 low length, in cycles
  int   checks = 0, errors = 0;
  int   cyc = 0, run = 0;
  bit   prev_key = 1'b0, armed = 1'b0, sb_on = 1'b1;
  int   busy_cnt = 0, err_cnt = 0, rise_cnt = 0, first_rise = -1;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic sb_compare(input int got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got run %0d, expected no further runs", got);
    end else begin
      check("key_run", got, exp_q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (err) err_cnt++;
    if (key != prev_key) begin
      if (key) begin
        rise_cnt++;
        if (first_rise < 0) first_rise = cyc;
      end
      if (sb_on && (prev_key || armed)) sb_compare(prev_key ? run : -run);
      if (key) armed = 1'b1;
      run = 1;
    end else begin
      run++;
    end
    prev_key = key;
  endtask

  task automatic clear_counts();
    busy_cnt = 0; err_cnt = 0; rise_cnt = 0; first_rise = -1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; valid = 1'b0; digit = 4'd0;
    tick(); tick();
    reset_n = 1'b1;
    exp_q.delete();
    prev_key = 1'b0; run = 0; armed = 1'b0; sb_on = 1'b1;
    clear_counts();
  endtask

  task automatic push(input logic [3:0] d, output int hs);
    int w = 0;
    while (!ready && w < BOUND) begin tick(); w++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL push_wait: ready got 0, expected 1 within %0d cycles", BOUND);
    end
    digit = d; valid = 1'b1;
    tick();
    hs = cyc;
    valid = 1'b0; digit = 4'd0;
  endtask

  task automatic sb_char(input logic [4:0] pat);
    for (int i = 4; i >= 0; i--) begin
      exp_q.push_back(pat[i] ? 3 * U : U);
      exp_q.push_back(i > 0 ? -U : -3 * U);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    tick(); tick();
    while (busy && w < BOUND) begin tick(); w++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy got 1, expected 0 within %0d cycles", BOUND);
    end
    repeat (4) tick();
  endtask

  task automatic add_vec(input logic [3:0] c, input bit ok, input bit sp,
                         input logic [4:0] p, input int u);
    vec_t v;
    v.code = c; v.ok = ok; v.space = sp; v.pat = p; v.units = u;
    vecs.push_back(v);
  endtask

  initial begin
    int hs, h0, w;
    bit is_char;

    add_vec(4'd0,  1, 0, 5'b11111, 22);
    add_vec(4'd1,  1, 0, 5'b01111, 20);
    add_vec(4'd2,  1, 0, 5'b00111, 18);
    add_vec(4'd3,  1, 0, 5'b00011, 16);
    add_vec(4'd4,  1, 0, 5'b00001, 14);
    add_vec(4'd5,  1, 0, 5'b00000, 12);
    add_vec(4'd6,  1, 0, 5'b10000, 14);
    add_vec(4'd7,  1, 0, 5'b11000, 16);
    add_vec(4'd8,  1, 0, 5'b11100, 18);
    add_vec(4'd9,  1, 0, 5'b11110, 20);
    add_vec(4'd10, 0, 0, 5'b00000, 0);
    add_vec(4'd12, 0, 0, 5'b00000, 0);
    add_vec(4'd14, 0, 0, 5'b00000, 0);
`ifdef MORSE_WORD_GAP_EN
    add_vec(4'd15, 1, 1, 5'b00000, 7);
`else
    add_vec(4'd15, 0, 0, 5'b00000, 0);
`endif

    // Reset state
    do_reset();
    check("reset_key", key, 0);
    check("reset_err", err, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", ready, 1);

    // One code per reset: timing, duration, latency and error pulse
    foreach (vecs[i]) begin
      is_char = vecs[i].ok && !vecs[i].space;
      do_reset();
      push(vecs[i].code, hs);
      if (is_char) sb_char(vecs[i].pat);
      wait_idle();
      check($sformatf("busy_len_code%0d", vecs[i].code), busy_cnt, vecs[i].units * U);
      check($sformatf("err_pulses_code%0d", vecs[i].code), err_cnt, vecs[i].ok ? 0 : 1);
      check($sformatf("rises_code%0d", vecs[i].code), rise_cnt, is_char ? 5 : 0);
      if (is_char) check($sformatf("latency_code%0d", vecs[i].code), first_rise - hs, 2);
      check($sformatf("sb_left_code%0d", vecs[i].code), exp_q.size(), is_char ? 1 : 0);
    end

    // Back-to-back 0 then 9: char gap between them is exactly 3 units
    do_reset();
    push(4'd0, hs); sb_char(5'b11111);
    push(4'd9, hs); sb_char(5'b11110);
    wait_idle();
    check("b2b_busy", busy_cnt, 42 * U);
    check("b2b_rises", rise_cnt, 10);
    check("b2b_sb_left", exp_q.size(), 1);

    // FIFO fill: ready drops on the 4th queued digit, returns one cycle after the next pop
    do_reset();
    push(4'd8, h0); sb_char(5'b11100);
    push(4'd1, hs); sb_char(5'b01111);
    push(4'd2, hs); sb_char(5'b00111);
    push(4'd3, hs); sb_char(5'b00011);
    push(4'd4, hs); sb_char(5'b00001);
    check("full_ready_low", ready, 0);
    w = 0;
    while (!ready && w < BOUND) begin tick(); w++; end
    check("full_ready_return", cyc - h0, 1 + 18 * U);
    push(4'd6, hs); sb_char(5'b10000);
    wait_idle();
    check("full_busy", busy_cnt, 100 * U);
    check("full_rises", rise_cnt, 30);
    check("full_sb_left", exp_q.size(), 1);

    // Word space between 1 and 2
    do_reset();
    push(4'd1, hs); sb_char(5'b01111);
    push(4'hF, hs);
`ifdef MORSE_WORD_GAP_EN
    exp_q[exp_q.size() - 1] = exp_q[exp_q.size() - 1] - 7 * U;
`endif
    push(4'd2, hs); sb_char(5'b00111);
    wait_idle();
`ifdef MORSE_WORD_GAP_EN
    check("wgap_err", err_cnt, 0);
    check("wgap_busy", busy_cnt, 45 * U);
`else
    check("wgap_err", err_cnt, 1);
    check("wgap_busy", busy_cnt, 38 * U);
`endif
    check("wgap_rises", rise_cnt, 10);
    check("wgap_sb_left", exp_q.size(), 1);

    // Reset mid-dash with three digits queued
    do_reset();
    sb_on = 1'b0;
    push(4'd0, hs);
    push(4'd0, hs);
    push(4'd0, hs);
    w = 0;
    while (!key && w < BOUND) begin tick(); w++; end
    check("midreset_key_seen", key, 1);
    tick(); tick();
    reset_n = 1'b0;
    tick();
    check("midreset_key", key, 0);
    check("midreset_busy", busy, 0);
    check("midreset_ready", ready, 1);
    reset_n = 1'b1;
    clear_counts();
    repeat (30 * U) tick();
    check("midreset_no_marks", rise_cnt, 0);
    check("midreset_busy_cnt", busy_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
